// File: rtl/icache_fetch_queue_if.sv
// Groups the ICache-response enqueue side and the decode-facing dequeue side
// of the fetch queue into one bundle.
interface icache_fetch_queue_if #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned VADDR_WIDTH = 39
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic                   enq_valid;
  logic [DATA_WIDTH-1:0]  enq_data;
  logic [VADDR_WIDTH-1:0] enq_pc;
  logic                   flush;
  logic                   can_issue;
  logic                   deq_valid;
  logic                   deq_ready;
  logic [DATA_WIDTH-1:0]  deq_data;
  logic [VADDR_WIDTH-1:0] deq_pc;
  logic [CntW-1:0]        count;
  logic                   overflow;

  // Frontend / consumer side.
  modport master (
    output enq_valid, enq_data, enq_pc, flush, deq_ready,
    input  can_issue, deq_valid, deq_data, deq_pc, count, overflow
  );

  // Queue side.
  modport slave (
    input  enq_valid, enq_data, enq_pc, flush, deq_ready,
    output can_issue, deq_valid, deq_data, deq_pc, count, overflow
  );
endinterface

// File: rtl/icache_fetch_queue.sv
// Circular buffer between the non-stallable ICache response and decode. can_issue
// reserves room for every response that may still be in flight.
module icache_fetch_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned VADDR_WIDTH = 39,
  parameter int unsigned SKID        = 2
) (
  input logic                  clock,
  input logic                  reset,
  icache_fetch_queue_if.slave  io
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0]  data_mem [DEPTH];
  logic [VADDR_WIDTH-1:0] pc_mem   [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            deq_fire, enq_fire;

  assign io.deq_valid = (count_q != '0);
  assign io.deq_data  = data_mem[head_q];
  assign io.deq_pc    = pc_mem[head_q];
  assign io.count     = count_q;
  assign io.overflow  = overflow_q;
  // Registered occupancy only, so the frontend sees no same-cycle enq/deq path.
  assign io.can_issue = (CntW'(DEPTH) - count_q) >= CntW'(SKID + 1);

  assign deq_fire = io.deq_valid && io.deq_ready;
  assign enq_fire = io.enq_valid && !io.flush && ((count_q < CntW'(DEPTH)) || deq_fire);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (io.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq_fire) head_d = head_q + 1'b1;
      if (enq_fire) tail_d = tail_q + 1'b1;
      count_d = count_q + CntW'(enq_fire) - CntW'(deq_fire);
      // Only a full queue with no dequeue can refuse a valid response.
      if (io.enq_valid && !enq_fire) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && enq_fire) begin
      data_mem[tail_q] <= io.enq_data;
      pc_mem[tail_q]   <= io.enq_pc;
    end
  end
endmodule

// File: tb/tb_icache_fetch_queue.sv
// Directed bench for icache_fetch_queue: a queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_icache_fetch_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 39;
  localparam int unsigned SKID  = 2;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } pkt_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  icache_fetch_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .VADDR_WIDTH(AW)) bus ();

  icache_fetch_queue #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .VADDR_WIDTH(AW), .SKID(SKID)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (bus.slave)
  );

  int   n_tests = 0;
  int   n_fails = 0;
  pkt_t mq[$];
  logic m_ovf    = 1'b0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of packets updated on each rising edge.
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      m_ovf    = 1'b0;
      check_en = 1'b1;
    end else if (bus.flush) begin
      mq.delete();
    end else begin
      automatic bit df = (mq.size() != 0) && bus.deq_ready;
      automatic bit acc = bus.enq_valid && ((mq.size() < DEPTH) || df);
      if (bus.enq_valid && !acc) m_ovf = 1'b1;
      if (df) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: bus.enq_pc, data: bus.enq_data});
    end
  end

  // Outputs depend only on registered state, so sample mid-cycle.
  always @(negedge clock) begin
    if (check_en) begin
      chk("deq_valid", DW'(bus.deq_valid), DW'(mq.size() != 0));
      chk("count", DW'(bus.count), DW'(mq.size()));
      chk("can_issue", DW'(bus.can_issue), DW'((DEPTH - mq.size()) >= SKID + 1));
      chk("overflow", DW'(bus.overflow), DW'(m_ovf));
      if (mq.size() != 0) begin
        chk("deq_pc", DW'(bus.deq_pc), DW'(mq[0].pc));
        chk("deq_data", bus.deq_data, mq[0].data);
      end
    end
  end

  task automatic cyc(input logic ev, input logic [AW-1:0] pc, input logic [DW-1:0] d,
                     input logic dr, input logic fl);
    bus.enq_valid = ev;
    bus.enq_pc    = pc;
    bus.enq_data  = d;
    bus.deq_ready = dr;
    bus.flush     = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    automatic int k = 0;
    automatic logic [DW-1:0] aa = {16{8'hAA}};
    bus.enq_valid = 1'b0;
    bus.enq_pc    = '0;
    bus.enq_data  = '0;
    bus.deq_ready = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_deq_valid", DW'(bus.deq_valid), DW'(0));
    chk("rst_count", DW'(bus.count), DW'(0));
    chk("rst_can_issue", DW'(bus.can_issue), DW'(1));
    chk("rst_overflow", DW'(bus.overflow), DW'(0));

    // Single packet, held then consumed.
    cyc(1'b1, AW'(39'h80000000), aa, 1'b0, 1'b0);
    chk("one_valid", DW'(bus.deq_valid), DW'(1));
    chk("one_pc", DW'(bus.deq_pc), DW'(39'h80000000));
    chk("one_data", bus.deq_data, aa);
    chk("one_count", DW'(bus.count), DW'(1));
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("one_drained_count", DW'(bus.count), DW'(0));
    chk("one_drained_valid", DW'(bus.deq_valid), DW'(0));

    // Streaming with the consumer always ready.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, AW'(32'h1000 + 16 * i), DW'(i + 100), 1'b1, 1'b0);
      chk("stream_count_le1", DW'(bus.count <= 1), DW'(1));
      if (bus.deq_valid) begin
        chk("stream_pc", DW'(bus.deq_pc), DW'(32'h1000 + 16 * k));
        k++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      if (bus.deq_valid) begin
        chk("stream_pc", DW'(bus.deq_pc), DW'(32'h1000 + 16 * k));
        k++;
      end
    end
    chk("stream_all_seen", DW'(k), DW'(20));

    // Fill with the consumer stalled.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, AW'(32'h2000 + 16 * i), DW'(i + 200), 1'b0, 1'b0);
      chk("fill_can_issue", DW'(bus.can_issue), DW'(i + 1 <= 5));
    end
    chk("fill_count", DW'(bus.count), DW'(8));
    cyc(1'b1, AW'(32'h3000), DW'(300), 1'b0, 1'b0);
    chk("ovf_set", DW'(bus.overflow), DW'(1));
    chk("ovf_count", DW'(bus.count), DW'(8));
    chk("ovf_head", DW'(bus.deq_pc), DW'(32'h2000));

    // Full queue: simultaneous enq and deq.
    cyc(1'b1, AW'(32'h4000), DW'(400), 1'b1, 1'b0);
    chk("full_swap_count", DW'(bus.count), DW'(8));
    chk("full_swap_head", DW'(bus.deq_pc), DW'(32'h2010));
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("tail_pc", DW'(bus.deq_pc), DW'(32'h4000));
    chk("tail_data", bus.deq_data, DW'(400));
    chk("tail_count", DW'(bus.count), DW'(1));

    // Flush a 5-entry queue together with an enqueue.
    for (int i = 0; i < 4; i++) cyc(1'b1, AW'(32'h5000 + 16 * i), DW'(i + 500), 1'b0, 1'b0);
    chk("pre_flush_count", DW'(bus.count), DW'(5));
    cyc(1'b1, AW'(32'h6000), DW'(600), 1'b0, 1'b1);
    chk("flush_count", DW'(bus.count), DW'(0));
    chk("flush_valid", DW'(bus.deq_valid), DW'(0));
    chk("flush_can_issue", DW'(bus.can_issue), DW'(1));
    chk("flush_keeps_ovf", DW'(bus.overflow), DW'(1));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("flushed_never_seen", DW'(bus.deq_valid), DW'(0));
    end

    // Post-flush enqueue lands at slot 0, then a mid-run reset clears everything.
    cyc(1'b1, AW'(32'h7000), DW'(700), 1'b0, 1'b0);
    cyc(1'b1, AW'(32'h7010), DW'(701), 1'b0, 1'b0);
    chk("post_flush_head", DW'(bus.deq_pc), DW'(32'h7000));
    reset = 1'b1;
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("mid_rst_count", DW'(bus.count), DW'(0));
    chk("mid_rst_ovf", DW'(bus.overflow), DW'(0));
    chk("mid_rst_can_issue", DW'(bus.can_issue), DW'(1));
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end
endmodule

// File: doc/icache_fetch_queue.md
Name: icache_fetch_queue

Overview:
- Buffers instruction-fetch responses from the ICache (valid-only, no backpressure) and presents them to the decode/fetch-buffer stage over a ready/valid handshake.
- Because the ICache response arrives two cycles after its request with no way to stall it, the block produces a conservative can_issue signal. The frontend gates new ICache requests with it, so every response that can still be in flight always has a free slot.
- Sits directly downstream of ICacheModule's io_resp.

Parameters:
DEPTH, 8, number of queue entries; must be >= SKID+1 and a power of two
DATA_WIDTH, 128, fetch packet width (fetchBytes*8)
VADDR_WIDTH, 39, width of the fetch PC carried with each packet
SKID, 2, maximum ICache responses that can be in flight after a request fires (s1, s2)

Ports:
clock  in  1  sole clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
enq_valid  in  1  ICache io_resp.valid
enq_data  in  DATA_WIDTH  ICache io_resp.bits.data
enq_pc  in  VADDR_WIDTH  fetch PC associated with the response (frontend s2 PC)
flush  in  1  redirect/kill; discards all queued and same-cycle enqueued packets
can_issue  out  1  frontend may fire a new ICache request this cycle
deq_valid  out  1  head entry valid
deq_ready  in  1  consumer accepts head
deq_data  out  DATA_WIDTH  head packet data
deq_pc  out  VADDR_WIDTH  head packet PC
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky error: an enqueue was dropped because the queue was full

Behaviour:
- Storage: DEPTH-entry circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus an occupancy counter.
- Reset (synchronous): head=tail=count=0, overflow=0. Outputs are then deq_valid=0, can_issue=1. deq_data and deq_pc are don't-care while deq_valid=0.
- Dequeue:
  - deq_fire = deq_valid && deq_ready.
  - deq_valid = (count != 0).
  - deq_data and deq_pc are driven combinationally from the head entry.
  - On deq_fire, head advances.
- Enqueue:
  - enq_fire = enq_valid && !flush && (count < DEPTH || deq_fire).
  - The entry is written at tail and tail advances.
  - Latency: data enqueued in cycle t is visible on deq in cycle t+1 at the earliest. There is no combinational bypass.
- Full with simultaneous deq_fire: the enqueue is accepted and count is unchanged.
- Full without deq_fire and enq_valid=1, flush=0: the packet is dropped, overflow is set and stays 1 until reset, and no pointers change.
- Count update: count_next = count + enq_fire - deq_fire. It never exceeds DEPTH or goes below 0.
- Flush (priority over everything):
  - Next cycle: head=tail=0, count=0.
  - enq and deq in the flush cycle have no effect on state.
  - deq_valid may still be 1 during the flush cycle; the consumer ignores the output under flush.
  - overflow is not cleared by flush.
- can_issue = (DEPTH - count) >= SKID+1, computed combinationally from the registered count only; it does not depend on enq or deq in the same cycle.
  - This guarantees that the up to SKID responses already in flight, plus the one being requested, all fit.
  - With defaults: can_issue=1 iff count <= 5.
- Reset asserted mid-operation: all stored packets are discarded exactly as after a power-up reset, including clearing overflow.
- The block does not track misses. Responses that never arrive (ICache miss or s2 kill) only make can_issue conservative; they never cause overflow.

Test Plan:
- Reset then idle → deq_valid=0, count=0, can_issue=1, overflow=0.
- Single enq (pc=0x80000000, data=0x...AA) with deq_ready=0 → next cycle deq_valid=1, deq_pc=0x80000000, count=1. Raise deq_ready → the following cycle count=0, deq_valid=0.
- Streaming: enq 20 consecutive packets with PCs 0x1000+16*i, deq_ready held 1 → all emerge in order with one-cycle latency, count never exceeds 1, pointers wrap twice.
- Fill to 8 with deq_ready=0 → can_issue drops to 0 when count reaches 6. A 9th enq → overflow=1 and count stays 8; the head is still the first packet.
- Full queue with enq_valid=1 and deq_ready=1 in the same cycle → the enq is accepted, count stays 8, the new PC appears at the tail position after 7 further dequeues.
- Queue holding 5 entries, flush=1 together with enq_valid=1 → next cycle count=0, deq_valid=0, can_issue=1. The flushed packet never appears on deq. A previously set overflow stays 1.
